// File: rtl/softmax_norm.sv
// Softmax normalizer: buffers N exp() values, then emits each divided by their sum.
// Optional error flag enabled by defining SOFTMAX_NORM_ERR_EN.
module softmax_norm #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  real  in_data,
  output logic out_valid,
  input  logic out_ready,
  output real  out_data,
  output logic out_last,
  output logic busy,
  output logic err
);

  typedef enum logic {LOAD, NORM} state_t;

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  idx;
  real            sum;
  real            data_buf [N];
  logic           in_fire;
  logic           out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == LAST)) state_next = NORM;
      end
      NORM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = (idx == LAST);
        if (out_ready && (idx == LAST)) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  // Counters, sample buffer and running sum; a completed vector clears the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      sum <= 0.0;
      for (int i = 0; i < N; i++) data_buf[i] <= 0.0;
    end else begin
      if (in_fire) begin
        data_buf[cnt] <= in_data;
        sum           <= sum + in_data;
        if (cnt == LAST) begin
          cnt <= '0;
          idx <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (out_fire) begin
        if (out_last) begin
          idx <= '0;
          cnt <= '0;
          sum <= 0.0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // A zero sum yields zero outputs rather than dividing.
  always_comb begin
    out_data = 0.0;
    if ((state == NORM) && (sum != 0.0)) out_data = data_buf[idx] / sum;
  end

`ifdef SOFTMAX_NORM_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (in_fire) begin
      if ((in_data < 0.0) || ((cnt == LAST) && ((sum + in_data) == 0.0)))
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_norm.sv
// Directed self-checking bench for softmax_norm with N=4.
module tb_softmax_norm;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  real  in_data   = 0.0;
  logic in_ready;
  logic out_valid;
  logic out_last;
  logic busy;
  logic err;
  real  out_data;

  int   checks   = 0;
  int   failures = 0;
  logic err_en   = 1'b0;

  always #5 clk = ~clk;

  softmax_norm #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      $error("[TB] %s", tag);
    end
  endtask

  task automatic check_real(input string tag, input real observed, input real expected);
    checks++;
    assert ($realtobits(observed) === $realtobits(expected)) else begin
      failures++;
      $display("[TB] FAIL %s observed=%g expected=%g", tag, observed, expected);
      $error("[TB] %s", tag);
    end
  endtask

  // One accepted input; in_valid drops afterwards unless the next call re-raises it.
  task automatic apply_stimulus(input real value);
    check_bit("in_ready_load", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = value;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_output(input real expected, input logic last);
    check_bit("out_valid", out_valid, 1'b1);
    check_real("out_data", out_data, expected);
    check_bit("out_last", out_last, last);
    check_bit("busy_norm", busy, 1'b1);
    check_bit("in_ready_norm", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
  endtask

  initial begin
`ifdef SOFTMAX_NORM_ERR_EN
    err_en = 1'b1;
`endif
    step();
    step();
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_out_last", out_last, 1'b0);
    check_bit("rst_err", err, 1'b0);
    rst_n = 1'b1;
    step();
    check_bit("rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;

    // Basic vector, back-to-back, no stalls.
    apply_stimulus(1.0);
    apply_stimulus(2.0);
    apply_stimulus(3.0);
    apply_stimulus(4.0);
    check_output(0.1, 1'b0);
    check_output(0.2, 1'b0);
    check_output(0.3, 1'b0);
    check_output(0.4, 1'b1);
    check_bit("back_in_ready", in_ready, 1'b1);
    check_bit("back_out_valid", out_valid, 1'b0);
    check_bit("back_busy", busy, 1'b0);

    // Downstream stall on element 1.
    apply_stimulus(1.0);
    apply_stimulus(2.0);
    apply_stimulus(3.0);
    apply_stimulus(4.0);
    check_output(0.1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_real("stall_data", out_data, 0.2);
      check_bit("stall_in_ready", in_ready, 1'b0);
      check_bit("stall_valid", out_valid, 1'b0 | 1'b1);
      check_bit("stall_last", out_last, 1'b0);
    end
    check_output(0.2, 1'b0);
    check_output(0.3, 1'b0);
    check_output(0.4, 1'b1);

    // Streaming with in_valid held high; garbage during NORM must be ignored.
    in_valid = 1'b1;
    in_data = 1.0; step();
    in_data = 2.0; step();
    in_data = 3.0; step();
    in_data = 4.0; step();
    in_data = 100.0;
    check_output(0.1, 1'b0);
    check_output(0.2, 1'b0);
    check_output(0.3, 1'b0);
    check_output(0.4, 1'b1);
    check_bit("stream_in_ready", in_ready, 1'b1);
    in_data = 1.0; step();
    in_data = 1.0; step();
    in_data = 1.0; step();
    in_data = 2.0; step();
    in_valid = 1'b0;
    check_output(0.2, 1'b0);
    check_output(0.2, 1'b0);
    check_output(0.2, 1'b0);
    check_output(0.4, 1'b1);

    // All-zero vector.
    apply_stimulus(0.0);
    apply_stimulus(0.0);
    apply_stimulus(0.0);
    apply_stimulus(0.0);
    check_bit("zero_err", err, err_en);
    check_output(0.0, 1'b0);
    check_output(0.0, 1'b0);
    check_output(0.0, 1'b0);
    check_output(0.0, 1'b1);

    // Reset mid-vector discards the partial load.
    apply_stimulus(1.0);
    apply_stimulus(1.0);
    rst_n = 1'b0;
    step();
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_err", err, 1'b0);
    rst_n = 1'b1;
    step();
    check_bit("midrst_in_ready", in_ready, 1'b1);
    check_bit("midrst_out_valid_rel", out_valid, 1'b0);
    apply_stimulus(1.0);
    apply_stimulus(1.0);
    apply_stimulus(1.0);
    check_bit("partial_no_out", out_valid, 1'b0);
    apply_stimulus(1.0);
    check_output(0.25, 1'b0);
    check_output(0.25, 1'b0);
    check_output(0.25, 1'b0);
    check_output(0.25, 1'b1);

    // Negative element.
    apply_stimulus(2.0);
    check_bit("neg_err_before", err, 1'b0);
    apply_stimulus(-1.0);
    check_bit("neg_err_after", err, err_en);
    apply_stimulus(1.0);
    apply_stimulus(2.0);
    check_output(0.5, 1'b0);
    check_output(-0.25, 1'b0);
    check_output(0.25, 1'b0);
    check_output(0.5, 1'b1);
    check_bit("neg_err_sticky", err, err_en);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/softmax_norm.md
SOFTMAX_NORM -- requirements
Module: softmax_norm

Interface
REQ-001 Parameter N, default 4: number of exp() values per vector; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream exp() result present on in_data.
REQ-005 in_ready  output  1  block accepts in_data this cycle.
REQ-006 in_data  input  real  one exp() value from the upstream exponential stage.
REQ-007 out_valid  output  1  normalized element present on out_data.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  real  buf[idx] divided by the vector sum.
REQ-010 out_last  output  1  high with out_valid on element N-1 of the vector.
REQ-011 busy  output  1  high whenever state is NORM.
REQ-012 err  output  1  sticky error flag; behaviour per Configuration.

Function
REQ-013 The FSM SHALL have two states: LOAD (collect N inputs) and NORM (emit N outputs).
REQ-014 A transfer SHALL occur on a rising edge where valid and ready are both high; there is no other handshake.
REQ-015 In LOAD, in_ready SHALL be 1, out_valid SHALL be 0, and each accepted value is written to buf[cnt]; sum += in_data; cnt++.
REQ-016 On accepting element N-1, the FSM SHALL enter NORM on that edge with sum final, cnt=0, idx=0.
REQ-017 In NORM, in_ready SHALL be 0 and out_valid SHALL be 1; out_data = buf[idx]/sum, combinational from registers.
REQ-018 Latency: first out_valid SHALL be high the cycle after the N-th input transfer.
REQ-019 Each output transfer SHALL increment idx; out_last = (idx == N-1).
REQ-020 On the transfer with out_last high, the FSM SHALL return to LOAD with sum=0.0, cnt=0, idx=0; in_ready is high in the next cycle.
REQ-021 While out_valid is high and out_ready is low, out_data, out_last and idx SHALL hold stable.
REQ-022 Inputs presented while in NORM SHALL NOT be accepted and SHALL NOT alter buf or sum.
REQ-023 If sum == 0.0 in NORM, out_data SHALL be 0.0 for every element (no division performed).
REQ-024 Throughput: one input per cycle in LOAD and one output per cycle in NORM; one vector per 2N cycles minimum.

Reset
REQ-025 While rst_n is low: state=LOAD, cnt=0, idx=0, sum=0.0, buf[*]=0.0, err=0, out_valid=0, out_last=0, busy=0, in_ready=1 once released.
REQ-026 Reset asserted mid-vector (either state) SHALL discard the partial vector; no outputs for it are produced after release.

Configuration
REQ-027 Macro SOFTMAX_NORM_ERR_EN SHALL control the error-checking feature.
REQ-028 With SOFTMAX_NORM_ERR_EN defined: err SHALL set on acceptance of any in_data < 0.0, and on entry to NORM with sum == 0.0; once set it SHALL remain set until reset. Data flow is unaffected.
REQ-029 Without SOFTMAX_NORM_ERR_EN: err SHALL be tied to 0; negative inputs are summed normally; the port list is unchanged.

Verification
REQ-030 N=4, inputs 1.0,2.0,3.0,4.0 back-to-back, out_ready=1 -> outputs 0.1,0.2,0.3,0.4 on consecutive cycles starting the cycle after the 4th accept; out_last on 0.4.
REQ-031 Same vector, out_ready low for 3 cycles on element 1 -> out_data holds 0.2, in_ready stays 0, then the sequence resumes without loss.
REQ-032 Inputs 0.0 x4 -> four outputs of 0.0; err=1 with the macro, err=0 without it.
REQ-033 Inputs 2.0,-1.0,1.0,2.0 with the macro -> err rises on the edge accepting -1.0; outputs 0.5,-0.25,0.25,0.5.
REQ-034 rst_n pulsed low after 2 of 4 inputs -> after release in_ready=1 and out_valid=0; a fresh vector 1,1,1,1 yields 0.25 x4.
REQ-035 Two vectors streamed with in_valid held high -> no input is accepted during NORM; the second vector normalizes independently of the first.
